// File: rtl/dzcpu_uop_pkg.sv
// Shared encodings for the dzcpu micro-op sequencer: micro-op field positions,
// flow codes, the jcb action code and the sequencer state encoding.
package dzcpu_uop_pkg;

  localparam int FLOW_HI = 11;
  localparam int FLOW_LO = 9;
  localparam int ACT_HI  = 8;
  localparam int ACT_LO  = 5;
  localparam int OPND_HI = 4;
  localparam int OPND_LO = 0;

  typedef enum logic [2:0] {
    FLOW_OP        = 3'd0,
    FLOW_INC       = 3'd1,
    FLOW_EOF       = 3'd2,
    FLOW_INC_EOF   = 3'd3,
    FLOW_INC_EOF_Z = 3'd4
  } flow_e;

  localparam logic [3:0] ACT_JCB = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_CBJUMP = 3'd4
  } state_e;

  function automatic logic [11:0] make_uop(input logic [2:0] flow, input logic [3:0] action,
                                           input logic [4:0] operand);
    return {flow, action, operand};
  endfunction

endpackage

// File: rtl/dzcpu_uop_sequencer_if.sv
// Sequencer-side bundle: memory fetch, opcode/CB LUTs, ucode ROM and datapath gating.
// master = the sequencer, slave = the surrounding core.
interface dzcpu_uop_sequencer_if #(
  parameter int UPC_W = 8,
  parameter int UOP_W = 12
);
  logic [7:0]       iMemData;
  logic             iMemValid;
  logic             oFetchReq;
  logic [7:0]       oMop;
  logic [UPC_W-1:0] iUopFlowIdx;
  logic [7:0]       oCbMop;
  logic [UPC_W-1:0] iCbFlowIdx;
  logic [UPC_W-1:0] oUopAddr;
  logic [UOP_W-1:0] iUop;
  logic             iFlagZ;
  logic             iStall;
  logic             oUopValid;
  logic             oIncPc;
  logic             oInstrDone;
  logic             oError;

  modport master (
    input  iMemData, iMemValid, iUopFlowIdx, iCbFlowIdx, iUop, iFlagZ, iStall,
    output oFetchReq, oMop, oCbMop, oUopAddr, oUopValid, oIncPc, oInstrDone, oError
  );

  modport slave (
    output iMemData, iMemValid, iUopFlowIdx, iCbFlowIdx, iUop, iFlagZ, iStall,
    input  oFetchReq, oMop, oCbMop, oUopAddr, oUopValid, oIncPc, oInstrDone, oError
  );
endinterface

// File: rtl/dzcpu_uop_wdog.sv
// Per-instruction micro-op watchdog (built only with DZCPU_UOP_WDOG_EN): trips combinationally
// on the MAX_UOPS-th executed uop that does not end the instruction; error is sticky until reset.
module dzcpu_uop_wdog #(
  parameter int MAX_UOPS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  input  logic eof,
  output logic trip,
  output logic error
);
  localparam int CNT_W = $clog2(MAX_UOPS + 1);

  logic [CNT_W-1:0] cnt;

  assign trip = inc && !eof && (cnt == CNT_W'(MAX_UOPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        cnt <= cnt + 1'b1;
      end
      if (trip) begin
        error <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-op sequencer: FETCH -> DECODE -> EXEC (+CBJUMP), min 3 cycles per instruction;
// iStall freezes EXEC only. DZCPU_UOP_WDOG_EN adds the uop-count watchdog driving oError.
module dzcpu_uop_sequencer
  import dzcpu_uop_pkg::*;
#(
  parameter int UPC_W = 8,
  parameter int UOP_W = 12
`ifdef DZCPU_UOP_WDOG_EN
  , parameter int MAX_UOPS = 32
`endif
) (
  input  logic                   iClock,
  input  logic                   iReset,
  dzcpu_uop_sequencer_if.master  uif
);

  state_e           state;
  logic [UPC_W-1:0] upc;
  logic [7:0]       mop;
  logic [7:0]       cbmop;

  logic [2:0] flow;
  logic [3:0] action;
  logic       exec_go;
  logic       is_jcb;
  logic       flow_inc;
  logic       flow_eof;
  logic       end_ok;
  logic       wdog_trip;
  logic       wdog_err;

  assign flow    = uif.iUop[FLOW_HI:FLOW_LO];
  assign action  = uif.iUop[ACT_HI:ACT_LO];
  assign exec_go = (state == ST_EXEC) && !uif.iStall;
  assign is_jcb  = (action == ACT_JCB);

  always_comb begin
    flow_inc = 1'b0;
    flow_eof = 1'b0;
    case (flow)
      FLOW_OP:        ;
      FLOW_INC:       flow_inc = 1'b1;
      FLOW_EOF:       flow_eof = 1'b1;
      FLOW_INC_EOF:   begin flow_inc = 1'b1; flow_eof = 1'b1; end
      FLOW_INC_EOF_Z: begin flow_inc = 1'b1; flow_eof = uif.iFlagZ; end
      default:        flow_eof = 1'b1;
    endcase
  end

  // A jcb redirects into the CB flow, so it never ends the instruction itself.
  assign end_ok = flow_eof && !is_jcb;

`ifdef DZCPU_UOP_WDOG_EN
  dzcpu_uop_wdog #(.MAX_UOPS(MAX_UOPS)) u_wdog (
    .clk   (iClock),
    .rst_n (iReset),
    .clr   (state == ST_DECODE),
    .inc   (exec_go),
    .eof   (end_ok),
    .trip  (wdog_trip),
    .error (wdog_err)
  );
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  assign uif.oFetchReq  = (state == ST_FETCH);
  assign uif.oUopAddr   = upc;
  assign uif.oUopValid  = exec_go;
  assign uif.oIncPc     = exec_go && flow_inc;
  assign uif.oInstrDone = exec_go && (end_ok || wdog_trip);
  assign uif.oMop       = mop;
  assign uif.oCbMop     = cbmop;
  assign uif.oError     = wdog_err;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state <= ST_IDLE;
      upc   <= '0;
      mop   <= '0;
      cbmop <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (uif.iMemValid) begin
            mop   <= uif.iMemData;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          upc   <= uif.iUopFlowIdx;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (exec_go) begin
            if (wdog_trip || end_ok) begin
              state <= ST_FETCH;
            end else if (is_jcb) begin
              cbmop <= uif.iMemData;
              state <= ST_CBJUMP;
            end else begin
              upc <= upc + 1'b1;
            end
          end
        end
        ST_CBJUMP: begin
          upc   <= uif.iCbFlowIdx;
          state <= ST_EXEC;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Directed bench for dzcpu_uop_sequencer: ROM/LUT modelled by the bench, expected values hand-computed.
module tb_dzcpu_uop_sequencer;
  import dzcpu_uop_pkg::*;

  logic iClock = 1'b0;
  logic iReset = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  logic [11:0] rom [256];

  dzcpu_uop_sequencer_if #(.UPC_W(8), .UOP_W(12)) uif ();

  assign uif.iUop = rom[uif.oUopAddr];

  dzcpu_uop_sequencer #(
    .UPC_W(8),
    .UOP_W(12)
`ifdef DZCPU_UOP_WDOG_EN
    , .MAX_UOPS(4)
`endif
  ) dut (
    .iClock (iClock),
    .iReset (iReset),
    .uif    (uif)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  // Starts in FETCH; returns after the cycle following oInstrDone (back in FETCH).
  task automatic run_instr(input logic [7:0] op, input logic [7:0] idx,
                           output int n_exec, output int n_inc,
                           output int first_a, output int last_a);
    logic done;
    n_exec  = 0;
    n_inc   = 0;
    first_a = -1;
    last_a  = -1;
    done    = 1'b0;
    uif.iMemValid   = 1'b1;
    uif.iMemData    = op;
    uif.iUopFlowIdx = idx;
    tick();
    uif.iMemValid = 1'b0;
    tick();
    for (int g = 0; g < 64 && !done; g++) begin
      if (uif.oUopValid) begin
        n_exec++;
        if (first_a < 0) first_a = int'(uif.oUopAddr);
        last_a = int'(uif.oUopAddr);
      end
      if (uif.oIncPc) n_inc++;
      done = uif.oInstrDone;
      tick();
    end
    chk("instr_done_seen", {31'd0, done}, 1);
  endtask

  initial begin
    int ne, ni, fa, la;

    for (int i = 0; i < 256; i++) rom[i] = make_uop(FLOW_EOF, 4'h0, 5'h0);
    rom[0]  = make_uop(FLOW_INC_EOF, 4'h1, 5'h02);
    rom[13] = make_uop(FLOW_INC, 4'h2, 5'h01);
    rom[14] = make_uop(FLOW_OP, 4'h3, 5'h04);
    rom[15] = make_uop(FLOW_INC, ACT_JCB, 5'h00);
    rom[16] = make_uop(FLOW_EOF, 4'h5, 5'h06);
    rom[17] = make_uop(FLOW_INC, 4'h1, 5'h01);
    rom[18] = make_uop(FLOW_OP, 4'h2, 5'h02);
    rom[19] = make_uop(FLOW_INC_EOF_Z, 4'h3, 5'h03);
    rom[20] = make_uop(FLOW_OP, 4'h4, 5'h04);
    rom[21] = make_uop(FLOW_OP, 4'h5, 5'h05);
    rom[22] = make_uop(FLOW_EOF, 4'h6, 5'h06);
    for (int i = 40; i < 46; i++) rom[i] = make_uop(FLOW_OP, 4'h7, 5'h1F);

    uif.iMemData    = 8'h00;
    uif.iMemValid   = 1'b0;
    uif.iUopFlowIdx = 8'h00;
    uif.iCbFlowIdx  = 8'd16;
    uif.iFlagZ      = 1'b0;
    uif.iStall      = 1'b0;

    tick();
    tick();
    chk("rst_fetchreq", {31'd0, uif.oFetchReq}, 0);
    chk("rst_uopvalid", {31'd0, uif.oUopValid}, 0);
    chk("rst_incpc", {31'd0, uif.oIncPc}, 0);
    chk("rst_done", {31'd0, uif.oInstrDone}, 0);
    chk("rst_error", {31'd0, uif.oError}, 0);
    chk("rst_mop", {24'd0, uif.oMop}, 0);
    chk("rst_cbmop", {24'd0, uif.oCbMop}, 0);
    chk("rst_uaddr", {24'd0, uif.oUopAddr}, 0);

    // Minimum-latency single-uop instruction.
    iReset = 1'b1;
    #1;
    chk("idle_fetchreq", {31'd0, uif.oFetchReq}, 0);
    tick();
    chk("c1_fetchreq", {31'd0, uif.oFetchReq}, 1);
    chk("c1_uopvalid", {31'd0, uif.oUopValid}, 0);
    uif.iMemValid = 1'b1;
    uif.iMemData  = 8'h00;
    tick();
    uif.iMemValid = 1'b0;
    #1;
    chk("c2_dec_fetchreq", {31'd0, uif.oFetchReq}, 0);
    chk("c2_dec_uopvalid", {31'd0, uif.oUopValid}, 0);
    tick();
    chk("c3_uopvalid", {31'd0, uif.oUopValid}, 1);
    chk("c3_incpc", {31'd0, uif.oIncPc}, 1);
    chk("c3_done", {31'd0, uif.oInstrDone}, 1);
    chk("c3_uaddr", {24'd0, uif.oUopAddr}, 0);
    tick();
    chk("c4_fetchreq", {31'd0, uif.oFetchReq}, 1);
    chk("c4_done", {31'd0, uif.oInstrDone}, 0);

    // Conditional end on Z at row 19.
    uif.iFlagZ = 1'b1;
    run_instr(8'hA5, 8'd17, ne, ni, fa, la);
    chk("z1_exec_cnt", ne, 3);
    chk("z1_incpc_cnt", ni, 2);
    chk("z1_last_addr", la, 19);
    chk("z1_mop", {24'd0, uif.oMop}, 32'hA5);
    chk("z1_back_fetch", {31'd0, uif.oFetchReq}, 1);

    uif.iFlagZ = 1'b0;
    run_instr(8'h5A, 8'd17, ne, ni, fa, la);
    chk("z0_exec_cnt", ne, 6);
    chk("z0_incpc_cnt", ni, 2);
    chk("z0_first_addr", fa, 17);
    chk("z0_last_addr", la, 22);
    chk("z0_mop", {24'd0, uif.oMop}, 32'h5A);
`ifndef DZCPU_UOP_WDOG_EN
    chk("nowdog_error", {31'd0, uif.oError}, 0);
`endif

    // CB-prefixed path via jcb at row 15.
    uif.iMemValid   = 1'b1;
    uif.iMemData    = 8'hCB;
    uif.iUopFlowIdx = 8'd13;
    tick();
    uif.iMemValid = 1'b0;
    tick();
    chk("cb_r13_uaddr", {24'd0, uif.oUopAddr}, 13);
    chk("cb_r13_incpc", {31'd0, uif.oIncPc}, 1);
    tick();
    chk("cb_r14_incpc", {31'd0, uif.oIncPc}, 0);
    tick();
    uif.iMemData = 8'h7C;
    #1;
    chk("cb_r15_uaddr", {24'd0, uif.oUopAddr}, 15);
    chk("cb_r15_incpc", {31'd0, uif.oIncPc}, 1);
    chk("cb_r15_done", {31'd0, uif.oInstrDone}, 0);
    tick();
    chk("cbjump_uopvalid", {31'd0, uif.oUopValid}, 0);
    chk("cbjump_cbmop", {24'd0, uif.oCbMop}, 32'h7C);
    chk("cbjump_mop", {24'd0, uif.oMop}, 32'hCB);
    tick();
    chk("cb_r16_uaddr", {24'd0, uif.oUopAddr}, 16);
    chk("cb_r16_done", {31'd0, uif.oInstrDone}, 1);
    tick();
    chk("cb_back_fetch", {31'd0, uif.oFetchReq}, 1);

    // Stall for 3 cycles at row 18, then reset during row 20.
    uif.iMemValid   = 1'b1;
    uif.iMemData    = 8'h3E;
    uif.iUopFlowIdx = 8'd17;
    tick();
    uif.iMemValid = 1'b0;
    tick();
    chk("st_r17_incpc", {31'd0, uif.oIncPc}, 1);
    tick();
    uif.iStall = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_uaddr", {24'd0, uif.oUopAddr}, 18);
      chk("stall_incpc", {31'd0, uif.oIncPc}, 0);
      chk("stall_uopvalid", {31'd0, uif.oUopValid}, 0);
      chk("stall_done", {31'd0, uif.oInstrDone}, 0);
      tick();
    end
    uif.iStall = 1'b0;
    #1;
    chk("unstall_uaddr", {24'd0, uif.oUopAddr}, 18);
    chk("unstall_uopvalid", {31'd0, uif.oUopValid}, 1);
    tick();
    chk("resume_uaddr", {24'd0, uif.oUopAddr}, 19);
    chk("resume_incpc", {31'd0, uif.oIncPc}, 1);
    tick();
    chk("pre_rst_uaddr", {24'd0, uif.oUopAddr}, 20);

    iReset = 1'b0;
    #1;
    chk("mid_rst_uopvalid", {31'd0, uif.oUopValid}, 0);
    chk("mid_rst_done", {31'd0, uif.oInstrDone}, 0);
    chk("mid_rst_uaddr", {24'd0, uif.oUopAddr}, 0);
    chk("mid_rst_mop", {24'd0, uif.oMop}, 0);
    chk("mid_rst_cbmop", {24'd0, uif.oCbMop}, 0);
    chk("mid_rst_fetchreq", {31'd0, uif.oFetchReq}, 0);
    iReset = 1'b1;
    #1;
    chk("post_rst_idle", {31'd0, uif.oFetchReq}, 0);
    tick();
    chk("post_rst_fetch", {31'd0, uif.oFetchReq}, 1);
    run_instr(8'h11, 8'd0, ne, ni, fa, la);
    chk("post_rst_exec_cnt", ne, 1);
    chk("post_rst_incpc_cnt", ni, 1);
    chk("post_rst_mop", {24'd0, uif.oMop}, 32'h11);

`ifdef DZCPU_UOP_WDOG_EN
    run_instr(8'h77, 8'd40, ne, ni, fa, la);
    chk("wdog_exec_cnt", ne, 4);
    chk("wdog_last_addr", la, 43);
    chk("wdog_error", {31'd0, uif.oError}, 1);
    chk("wdog_fetch", {31'd0, uif.oFetchReq}, 1);
    run_instr(8'h01, 8'd0, ne, ni, fa, la);
    chk("wdog_sticky", {31'd0, uif.oError}, 1);
    iReset = 1'b0;
    #1;
    chk("wdog_rst_clear", {31'd0, uif.oError}, 0);
    iReset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
